// File: rtl/fetch_sequencer_if.sv
// Fetch loop bundle: PC register, instruction memory and decode handshake.
// master = fetch_sequencer side, slave = PC register / memory / decode side.
interface fetch_sequencer_if;
  logic [31:0] PCResult;
  logic [31:0] Address;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck;
  logic [31:0] IMemData;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] Instruction;
  logic [31:0] InstrPC;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        FetchError;

  modport master (
    input  PCResult, IMemAck, IMemData,
    input  InstrReady, BranchTaken, BranchTarget,
    output Address, IMemReq, IMemAddr,
    output InstrValid, Instruction, InstrPC,
    output FetchError
  );

  modport slave (
    output PCResult, IMemAck, IMemData,
    output InstrReady, BranchTaken, BranchTarget,
    input  Address, IMemReq, IMemAddr,
    input  InstrValid, Instruction, InstrPC,
    input  FetchError
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch loop sequencer: PC -> imem read -> decode handshake -> next PC.
// `define FETCH_TIMEOUT_EN adds a sticky fetch watchdog (ERROR state).
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic Clk,
  input  logic Reset,
  fetch_sequencer_if.master bus
);

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
`ifdef FETCH_TIMEOUT_EN
  localparam logic [1:0] ERR  = 2'd3;
`endif

  if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0]  state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] ptgt_q, ptgt_d;
  logic        pend_q, pend_d;
  logic [31:0] addr;
  logic [31:0] btgt;
  logic        tmo;

  assign btgt = bus.BranchTarget & ~32'h3;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // Counts cycles spent in REQ without an ack; zero on any other cycle.
  assign tmo = (state_q == REQ) && !bus.IMemAck &&
               (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign cnt_d = (state_q == REQ && !bus.IMemAck) ?
                 cnt_q + 1'b1 : '0;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bus.FetchError = (state_q == ERR);
`else
  assign tmo            = 1'b0;
  assign bus.FetchError = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    pend_d  = pend_q;
    ptgt_d  = ptgt_q;
    addr    = bus.PCResult;
    unique case (state_q)
      BOOT: begin
        state_d = REQ;
        if (bus.BranchTaken) addr = btgt;
      end
      REQ: begin
        if (bus.IMemAck) begin
          // Redirected fetches drop the returned word and refetch.
          if (bus.BranchTaken) begin
            addr   = btgt;
            pend_d = 1'b0;
          end else if (pend_q) begin
            addr   = ptgt_q;
            pend_d = 1'b0;
          end else begin
            instr_d = bus.IMemData;
            ipc_d   = bus.PCResult;
            state_d = HOLD;
          end
        end else begin
          if (bus.BranchTaken) begin
            pend_d = 1'b1;
            ptgt_d = btgt;
          end
`ifdef FETCH_TIMEOUT_EN
          if (tmo) state_d = ERR;
`endif
        end
      end
      HOLD: begin
        if (bus.BranchTaken) begin
          addr    = btgt;
          state_d = REQ;
        end else if (bus.InstrReady) begin
          addr    = bus.PCResult + 32'd4;
          state_d = REQ;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= BOOT;
      instr_q <= '0;
      ipc_q   <= '0;
      pend_q  <= 1'b0;
      ptgt_q  <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      pend_q  <= pend_d;
      ptgt_q  <= ptgt_d;
    end
  end

  assign bus.Address     = Reset ? addr : RESET_VECTOR;
  assign bus.IMemReq     = (state_q == REQ);
  assign bus.IMemAddr    = bus.PCResult;
  assign bus.InstrValid  = (state_q == HOLD);
  assign bus.Instruction = instr_q;
  assign bus.InstrPC     = ipc_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Drives the Address input of the ProgramCounter register and consumes its PCResult output, closing the fetch loop. It issues a read to instruction memory at PCResult, waits for the memory acknowledge, and presents the fetched word to decode with a valid/ready handshake. It produces the next PC (PCResult+4 or a branch redirect target), so the PC advances only when an instruction is accepted or squashed.

Parameters:
RESET_VECTOR, 32'h0000_0000, Address value driven while Reset is asserted.
TIMEOUT_CYCLES, 16, fetch watchdog limit in cycles; used only with FETCH_TIMEOUT_EN.

Ports:
Clk  in  1  system clock; all state updates on rising edge.
Reset  in  1  asynchronous, active-low reset (0 = reset asserted).
PCResult  in  32  current PC from ProgramCounter.
Address  out  32  next-PC value to ProgramCounter, combinational.
IMemReq  out  1  instruction memory read request.
IMemAddr  out  32  read address, equals PCResult while IMemReq=1.
IMemAck  in  1  one-cycle read completion; IMemData valid that cycle.
IMemData  in  32  instruction word.
InstrValid  out  1  fetched instruction available.
InstrReady  in  1  decode accepts the instruction.
Instruction  out  32  registered instruction word.
InstrPC  out  32  registered PC of Instruction.
BranchTaken  in  1  one-cycle redirect request.
BranchTarget  in  32  redirect target.
FetchError  out  1  sticky watchdog error; tied 0 without FETCH_TIMEOUT_EN.

Behaviour:
- Reset=0 (async): state BOOT; IMemReq=0, InstrValid=0, Instruction=0, InstrPC=0, pending redirect cleared, FetchError=0; Address=RESET_VECTOR.
- Default Address=PCResult (hold), except where stated below. Increment +4 wraps modulo 2^32. Redirect targets have bits [1:0] forced to 0.
- BOOT: one cycle after reset release, IMemReq=0. Next state REQ. BranchTaken in BOOT: Address=target; next state REQ.
- REQ: IMemReq=1 and IMemAddr=PCResult; both held stable until IMemAck. An outstanding request is never withdrawn.
  - BranchTaken without IMemAck: latch the target into the pending register; a later BranchTaken overwrites it.
  - IMemAck with a pending redirect or same-cycle BranchTaken (same-cycle target wins): discard IMemData; Address=target; clear pending; stay in REQ; InstrValid stays 0.
  - IMemAck with no redirect: Instruction<=IMemData, InstrPC<=PCResult; next state HOLD. Address holds.
- HOLD: InstrValid=1, IMemReq=0; Instruction and InstrPC stable.
  - InstrReady=1 and no BranchTaken: Address=PCResult+4; next state REQ; InstrValid falls the next cycle.
  - BranchTaken (wins over InstrReady): held instruction squashed; Address=target; next state REQ.
  - Otherwise: hold.
- Minimum fetch-to-fetch interval: REQ with immediate ack, then HOLD with immediate ready = 2 cycles per instruction.
- Reset mid-transaction: the request is abandoned; a late IMemAck after reset is ignored in BOOT.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined: a counter starts at REQ entry. If TIMEOUT_CYCLES cycles elapse with no IMemAck, the block enters state ERROR: IMemReq=0, InstrValid=0, FetchError=1 (sticky), Address holds. Only Reset exits ERROR.
- Undefined: no counter and no ERROR state; REQ waits indefinitely; FetchError tied 0.

Test Plan:
1. Reset=0 for 2 cycles, then release; memory acks every request immediately; InstrReady=1 -> Address=0 during reset; IMemAddr sequence 0,4,8,12; InstrPC matches each; one instruction per 2 cycles.
2. IMemAck delayed 3 cycles at PC=8 -> IMemReq and IMemAddr=8 held stable for 3 cycles; PCResult unchanged; no InstrValid until the ack.
3. HOLD at PC=4 with InstrReady=0 for 4 cycles -> InstrValid, Instruction and InstrPC stable; Address=4; after InstrReady=1, next IMemAddr=8.
4. BranchTaken with target 0x40 during a REQ wait at PC=12 -> ack data discarded, InstrValid stays 0, next IMemAddr=0x40. A second BranchTaken with target 0x80 before the ack -> next IMemAddr=0x80. Target 0x43 -> fetch at 0x40.
5. BranchTaken and InstrReady together in HOLD at PC=16 with target 0x100 -> no advance to 20; next IMemAddr=0x100. PCResult=0xFFFF_FFFC accepted -> Address=0.
6. With FETCH_TIMEOUT_EN: no ack for 16 cycles -> FetchError=1, IMemReq=0, FetchError stays 1 until reset. Reset asserted mid-wait without the macro -> IMemReq drops asynchronously; a later ack is ignored.
